// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and flag bundle for the sequential arithmetic unit
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_DIV  = 3'd2,
    OP_MUL  = 3'd3,
    OP_REM  = 3'd4,
    OP_MULH = 3'd5
  } op_e;
  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;
  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic dz;
  } flags_t;
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_REM;
  endfunction
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: shared shift-add multiplier / restoring divider, one step per enabled edge
module iter_muldiv import alu_pkg::*; #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           div,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] prod,
  output logic [N-1:0]   quo,
  output logic [N-1:0]   rem,
  output logic           last
);
  localparam int W = $clog2(N + 1);
  logic [2*N-1:0] acc, acc_nxt;
  logic [N-1:0]   sh, sh_nxt;
  logic [W-1:0]   cnt;
  logic [N:0]     add_s, shl, rem_nxt;
  logic [N+1:0]   t;
  assign add_s   = {1'b0, acc[2*N-1:N]} + (sh[0] ? {1'b0, a} : '0);
  assign shl     = {acc[N-1:0], sh[N-1]};
  assign t       = {1'b0, shl} - {2'b0, b};
  assign rem_nxt = t[N+1] ? shl : t[N:0];
  assign acc_nxt = div ? {{(N-1){1'b0}}, rem_nxt} : {add_s, acc[N-1:1]};
  assign sh_nxt  = div ? {sh[N-2:0], ~t[N+1]} : sh >> 1;
  assign prod    = acc_nxt;
  assign quo     = sh_nxt;
  assign rem     = rem_nxt[N-1:0];
  assign last    = cnt == W'(N - 1);
  // load seeds the shift register with the dividend or multiplier; each step advances one bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      sh  <= div ? a_in : b_in;
      cnt <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      sh  <= sh_nxt;
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/alu_arit_secuencial.sv
// alu_arit_secuencial: multi-cycle add/sub/mul/div unit with start/busy/done handshake
module alu_arit_secuencial import alu_pkg::*; #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   s,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         dz
);
  state_e         state;
  logic [2:0]     op_r;
  logic [N-1:0]   a_r, b_r, res, quo, rem;
  logic [2*N-1:0] prod;
  logic [N:0]     sum, dif;
  flags_t         flg, flg_c;
  logic           load, step, last, dz_c, iter, fin;
  assign load  = state == IDLE && start;
  assign step  = state == CALC;
  assign dz_c  = is_div(op_r) && b_r == '0;
  assign iter  = op_r == OP_MUL || op_r == OP_MULH || (is_div(op_r) && !dz_c);
  assign fin   = step && (!iter || last);
  assign sum   = {1'b0, a_r} + {1'b0, b_r};
  assign dif   = {1'b0, a_r} - {1'b0, b_r};
  assign busy  = state == CALC;
  assign carry = flg.carry;
  assign ovf   = flg.ovf;
  assign zero  = flg.zero;
  assign dz    = flg.dz;
  iter_muldiv #(.N(N)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .div   (load ? is_div(s) : is_div(op_r)),
    .a_in  (A),
    .b_in  (B),
    .a     (a_r),
    .b     (b_r),
    .prod  (prod),
    .quo   (quo),
    .rem   (rem),
    .last  (last)
  );
  // result and flag selection; codes outside the table fall back to add
  always_comb begin
    res       = sum[N-1:0];
    flg_c     = '0;
    flg_c.carry = sum[N];
    flg_c.ovf   = (a_r[N-1] == b_r[N-1]) && (sum[N-1] != a_r[N-1]);
    case (op_r)
      OP_SUB: begin
        res         = dif[N-1:0];
        flg_c.carry = dif[N];
        flg_c.ovf   = (a_r[N-1] != b_r[N-1]) && (dif[N-1] != a_r[N-1]);
      end
      OP_DIV: begin
        res         = dz_c ? '1 : quo;
        flg_c.carry = 1'b0;
        flg_c.ovf   = 1'b0;
      end
      OP_REM: begin
        res         = dz_c ? a_r : rem;
        flg_c.carry = 1'b0;
        flg_c.ovf   = 1'b0;
      end
      OP_MUL: begin
        res         = prod[N-1:0];
        flg_c.carry = |prod[2*N-1:N];
        flg_c.ovf   = 1'b0;
      end
      OP_MULH: begin
        res         = prod[2*N-1:N];
        flg_c.carry = 1'b0;
        flg_c.ovf   = 1'b0;
      end
      default: ;
    endcase
    flg_c.dz   = dz_c;
    flg_c.zero = res == '0;
  end
  // two-state control: latch operands on accept, register result and flags on the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      out   <= '0;
      flg   <= '0;
      done  <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        state <= CALC;
        op_r  <= s;
        a_r   <= A;
        b_r   <= B;
      end
      if (fin) begin
        state <= IDLE;
        out   <= res;
        flg   <= flg_c;
      end
    end
  end
endmodule

// File: doc/alu_arit_secuencial.md
Name: alu_arit_secuencial

Overview:
- Parametrised, multi-cycle successor to the combinational arithmetic mux of the ALU.
- Computes add, subtract, multiply (low and high half), quotient and remainder on N-bit unsigned operands.
- Multiply uses an iterative shift-add; divide uses a restoring algorithm, so large N needs no combinational multiplier or divider.
- Sits between the ALU operand registers and the result/flag mux; a start/busy/done handshake tells the ALU controller when to wait.

Parameters:
- N, 8, operand and result width (N >= 2).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while idle.
- A  in  N  operand A (unsigned).
- B  in  N  operand B (unsigned).
- s  in  3  operation select, sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; out and flags are valid from this cycle.
- out  out  N  result, held until the next accepted start.
- carry  out  1  add: carry-out; sub: borrow (A<B); mul-low: high half nonzero; else 0.
- ovf  out  1  add/sub: two's-complement signed overflow; else 0.
- zero  out  1  out == 0.
- dz  out  1  divide or remainder with B == 0.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous and active-low.
- Reset: state IDLE; busy, done, carry, ovf, zero and dz are 0; out is 0; counter and internal registers are 0.
- Operation codes (s):
  - 000 add.
  - 001 sub.
  - 010 quotient A/B.
  - 011 mul low N bits.
  - 100 remainder A%B.
  - 101 mul high N bits.
  - 110 and 111 are treated as add.
- State machine, two states:
  - IDLE to CALC on start=1 at edge k. A, B and s are latched at that edge; busy=1 from edge k.
  - CALC performs one step per edge.
  - CALC to IDLE at edge k+L. At that edge out/flags are registered, done=1 and busy=0.
  - done returns to 0 at the next edge.
- Latency L:
  - L=1 for add, sub, 110, 111, and divide/remainder with B==0.
  - L=N for mul (low and high) and for divide/remainder with B!=0.
- Handshake rules:
  - start while busy is ignored. Operands and op are not re-sampled, and no queueing occurs.
  - start in the done cycle (state is IDLE) is accepted. Back-to-back throughput is one result per L+1 cycles.
  - Changing A, B or s while busy has no effect on the result.
- Arithmetic:
  - Multiply:
    - Holds a 2N-bit product register and an N-bit multiplier shift register.
    - Each step conditionally adds A into the upper half, then shifts right by 1.
    - Low op: out = product[N-1:0], carry = |product[2N-1:N].
    - High op: out = product[2N-1:N].
  - Divide:
    - Holds an N+1-bit partial remainder and an N-bit quotient register.
    - Each step shifts left, trial-subtracts B, and restores on a negative result.
    - Quotient op: out = quotient. Remainder op: out = remainder.
  - Divide or remainder by zero: dz=1; quotient op gives out = all ones; remainder op gives out = A.
  - Add/sub use N+1-bit internal sums. out wraps modulo 2^N.
- Flags:
  - Registered together with out at edge k+L.
  - Hold until the next done.
  - Each completing operation overwrites every flag; unused flags are written as 0.
- Reset mid-operation: everything clears immediately and asynchronously; no done is produced. After release, the block is IDLE and accepts start on the first edge.
- Step counter: width $clog2(N+1), counts 0..N-1 in CALC; it cannot wrap because the exit is at N-1.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] op_e: OP_ADD, OP_SUB, OP_DIV, OP_MUL, OP_REM, OP_MULH.
  - typedef enum logic state_e: IDLE, CALC.
  - Flag struct {carry, ovf, zero, dz}.
- One sub-module is natural: iter_muldiv. It holds the shared shift registers and counter for the multiply and divide steps. It takes load/step/mode inputs and exposes product, quotient and remainder.
- The top level holds the FSM, the add/sub path, flag generation and the output registers.

Test Plan (N=8):
- Add 200+100: start, s=000 → done 1 cycle later; out=44, carry=1, ovf=0, zero=0.
- Sub 5-7: s=001 → L=1; out=254, carry=1, ovf=0. Signed case 127-(-128 as 128), s=001 → out=255, ovf=1.
- Multiply:
  - 13*11, s=011 → done exactly 8 cycles after start; out=143, carry=0.
  - 200*200, s=101 → out=156.
  - 200*200, s=011 → out=64, carry=1.
- Divide:
  - 100/7, s=010 → 8 cycles; out=14.
  - Same operands, s=100 → out=2.
  - 55/0, s=010 → L=1; out=255, dz=1.
  - 55%0, s=100 → out=55, dz=1.
- Handshake:
  - Start a mul, pulse start with a different A/s mid-operation → ignored; original result returned.
  - Start again in the done cycle → accepted; second done arrives L+1 cycles after the first.
- Reset:
  - Assert rst_n=0 at cycle 4 of a divide → busy, done, out and flags are 0 immediately; no done after release.
  - A fresh add completes normally after release.
